// File: rtl/tile_load_engine.sv
// Tile loader: reads `length` bytes one request at a time and emits them as tiles of TILE_ELEMS elements.
// Each tile write is a single-cycle pulse; memory backpressure comes from mem_gnt/mem_rvalid, with at most one read in flight.
module tile_load_engine #(
   parameter int DATA_WIDTH = 8,
   parameter int TILE_ELEMS = 32,
   parameter int TILE_WIDTH = DATA_WIDTH * TILE_ELEMS,
   parameter int ADDR_WIDTH = 24,
   parameter int LEN_WIDTH  = 20
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         is_matrix,
   input  logic [ADDR_WIDTH-1:0]        base_addr,
   input  logic [LEN_WIDTH-1:0]         length,
   input  logic [4:0]                   buffer_id,
   output logic                         busy,
   output logic                         done,
   output logic                         mem_req,
   output logic [ADDR_WIDTH-1:0]        mem_addr,
   input  logic                         mem_gnt,
   input  logic                         mem_rvalid,
   input  logic [DATA_WIDTH-1:0]        mem_rdata,
   output logic                         vec_write_enable,
   output logic [4:0]                   vec_write_buffer_id,
   output logic signed [DATA_WIDTH-1:0] vec_write_tile [0:TILE_ELEMS-1],
   output logic                         mat_write_enable,
   output logic [4:0]                   mat_write_buffer_id,
   output logic [TILE_WIDTH-1:0]        mat_write_tile
);

   localparam int SLOT_W = (TILE_ELEMS > 1) ? $clog2(TILE_ELEMS) : 1;

   typedef enum logic [2:0] {IDLE, REQ, WAIT, WRITE, DONE} state_t;

   state_t                  state_q, state_d;
   logic                    is_mat_q, is_mat_d;
   logic [ADDR_WIDTH-1:0]   base_q, base_d;
   logic [LEN_WIDTH-1:0]    len_q, len_d;
   logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
   logic [SLOT_W-1:0]       slot_q, slot_d;
   logic [4:0]              bid_q, bid_d;
   logic [DATA_WIDTH-1:0]   tile_q [0:TILE_ELEMS-1];
   logic [DATA_WIDTH-1:0]   tile_d [0:TILE_ELEMS-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         is_mat_q <= 1'b0;
         base_q   <= '0;
         len_q    <= '0;
         cnt_q    <= '0;
         slot_q   <= '0;
         bid_q    <= '0;
         for (int k = 0; k < TILE_ELEMS; k++) tile_q[k] <= '0;
      end else begin
         state_q  <= state_d;
         is_mat_q <= is_mat_d;
         base_q   <= base_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         slot_q   <= slot_d;
         bid_q    <= bid_d;
         for (int k = 0; k < TILE_ELEMS; k++) tile_q[k] <= tile_d[k];
      end
   end

   always_comb begin
      state_d  = state_q;
      is_mat_d = is_mat_q;
      base_d   = base_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      slot_d   = slot_q;
      bid_d    = bid_q;
      for (int k = 0; k < TILE_ELEMS; k++) tile_d[k] = tile_q[k];

      case (state_q)
         IDLE: begin
            if (start) begin
               is_mat_d = is_matrix;
               base_d   = base_addr;
               len_d    = length;
               bid_d    = buffer_id;
               cnt_d    = '0;
               slot_d   = '0;
               for (int k = 0; k < TILE_ELEMS; k++) tile_d[k] = '0;
               state_d  = (length != '0) ? REQ : DONE;
            end
         end
         REQ: begin
            if (mem_gnt) state_d = WAIT;
         end
         WAIT: begin
            if (mem_rvalid) begin
               tile_d[slot_q] = mem_rdata;
               cnt_d          = cnt_q + LEN_WIDTH'(1);
               slot_d         = slot_q + SLOT_W'(1);
               // Flush on a full tile or on the final element of the command.
               if (slot_q == SLOT_W'(TILE_ELEMS - 1) || cnt_d == len_q)
                  state_d = WRITE;
               else
                  state_d = REQ;
            end
         end
         WRITE: begin
            for (int k = 0; k < TILE_ELEMS; k++) tile_d[k] = '0;
            slot_d  = '0;
            state_d = (cnt_q == len_q) ? DONE : REQ;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);
   assign mem_req  = (state_q == REQ);
   // Count is only advanced in WAIT, so the address holds steady for the whole request.
   assign mem_addr = mem_req ? (base_q + ADDR_WIDTH'(cnt_q)) : '0;

   assign vec_write_enable    = (state_q == WRITE) && !is_mat_q;
   assign mat_write_enable    = (state_q == WRITE) &&  is_mat_q;
   assign vec_write_buffer_id = bid_q;
   assign mat_write_buffer_id = bid_q;

   for (genvar g = 0; g < TILE_ELEMS; g++) begin : g_tile_out
      assign vec_write_tile[g]                             = tile_q[g];
      assign mat_write_tile[g*DATA_WIDTH +: DATA_WIDTH]    = tile_q[g];
   end

endmodule

// File: tb/tb_tile_load_engine.sv
// Directed bench for tile_load_engine with a behavioural single-outstanding memory and write capture.
module tb_tile_load_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        is_matrix;
   logic [23:0] base_addr;
   logic [19:0] length;
   logic [4:0]  buffer_id;
   logic        busy;
   logic        done;
   logic        mem_req;
   logic [23:0] mem_addr;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [7:0]  mem_rdata;
   logic        vec_write_enable;
   logic [4:0]  vec_write_buffer_id;
   logic signed [7:0] vec_write_tile [0:31];
   logic        mat_write_enable;
   logic [4:0]  mat_write_buffer_id;
   logic [255:0] mat_write_tile;

   always #5 clk = ~clk;

   tile_load_engine dut (
      .clk                 (clk),
      .rst                 (rst),
      .start               (start),
      .is_matrix           (is_matrix),
      .base_addr           (base_addr),
      .length              (length),
      .buffer_id           (buffer_id),
      .busy                (busy),
      .done                (done),
      .mem_req             (mem_req),
      .mem_addr            (mem_addr),
      .mem_gnt             (mem_gnt),
      .mem_rvalid          (mem_rvalid),
      .mem_rdata           (mem_rdata),
      .vec_write_enable    (vec_write_enable),
      .vec_write_buffer_id (vec_write_buffer_id),
      .vec_write_tile      (vec_write_tile),
      .mat_write_enable    (mat_write_enable),
      .mat_write_buffer_id (mat_write_buffer_id),
      .mat_write_tile      (mat_write_tile)
   );

   logic [255:0] vt;
   always_comb begin
      vt = '0;
      for (int k = 0; k < 32; k++) vt[k*8 +: 8] = vec_write_tile[k];
   end

   int n_pass = 0;
   int n_chk  = 0;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Memory model and monitor state
   int          gnt_dly = 0;
   int          rv_dly  = 0;
   bit          pend;
   int          gwait, rv_wait;
   logic [23:0] req_addr, pend_addr;
   int          n_wr, n_vec, n_mat, n_done, n_rv, n_req_cyc;
   int          viol_addr, viol_multi, viol_both;
   logic [255:0] cap     [0:7];
   logic [4:0]   cap_bid [0:7];

   initial begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      pend = 1'b0; gwait = 0; rv_wait = 0; req_addr = '0; pend_addr = '0;
      forever begin
         @(negedge clk);
         if (mem_gnt) begin
            pend = 1'b1; rv_wait = 0; pend_addr = req_addr;
         end
         mem_gnt = 1'b0; mem_rvalid = 1'b0;
         if (vec_write_enable || mat_write_enable) begin
            if (n_wr < 8) begin
               cap[n_wr]     = mat_write_enable ? mat_write_tile : vt;
               cap_bid[n_wr] = mat_write_enable ? mat_write_buffer_id : vec_write_buffer_id;
            end
            n_wr++;
         end
         if (vec_write_enable) n_vec++;
         if (mat_write_enable) n_mat++;
         if (vec_write_enable && mat_write_enable) viol_both++;
         if (done) n_done++;
         if (mem_req) n_req_cyc++;
         if (pend && mem_req) viol_multi++;
         if (pend) begin
            if (rv_wait >= rv_dly) begin
               mem_rvalid = 1'b1; mem_rdata = pend_addr[7:0]; pend = 1'b0; n_rv++;
            end else rv_wait++;
         end else if (mem_req) begin
            if (gwait > 0 && mem_addr !== req_addr) viol_addr++;
            req_addr = mem_addr;
            if (gwait >= gnt_dly) begin
               mem_gnt = 1'b1; gwait = 0;
            end else gwait++;
         end
      end
   end

   function automatic logic [255:0] ramp(input int first, input int n);
      logic [255:0] r;
      r = '0;
      for (int k = 0; k < n; k++) r[k*8 +: 8] = 8'(first + k);
      return r;
   endfunction

   task automatic clr();
      n_wr = 0; n_vec = 0; n_mat = 0; n_done = 0; n_rv = 0; n_req_cyc = 0;
      viol_addr = 0; viol_multi = 0; viol_both = 0; gwait = 0;
   endtask

   task automatic cmd(input bit m, input logic [23:0] b, input logic [19:0] l, input logic [4:0] id);
      @(negedge clk);
      clr();
      is_matrix = m; base_addr = b; length = l; buffer_id = id; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 3000 && busy; i++) @(negedge clk);
      chk({tag, "_timeout"}, 256'(busy), 256'(0));
      repeat (3) @(negedge clk);
   endtask

   task automatic zchk(input string p);
      chk({p, "_busy"},    256'(busy),                256'(0));
      chk({p, "_done"},    256'(done),                256'(0));
      chk({p, "_req"},     256'(mem_req),             256'(0));
      chk({p, "_vwe"},     256'(vec_write_enable),    256'(0));
      chk({p, "_mwe"},     256'(mat_write_enable),    256'(0));
      chk({p, "_addr"},    256'(mem_addr),            256'(0));
      chk({p, "_vbid"},    256'(vec_write_buffer_id), 256'(0));
      chk({p, "_mbid"},    256'(mat_write_buffer_id), 256'(0));
      chk({p, "_mtile"},   mat_write_tile,            256'(0));
      chk({p, "_vtile"},   vt,                        256'(0));
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; is_matrix = 1'b0; base_addr = '0; length = '0; buffer_id = '0;
      clr();
      repeat (2) @(negedge clk);
      zchk("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Vector, two full tiles
      cmd(1'b0, 24'h000100, 20'd64, 5'd3);
      wait_idle("vec64");
      chk("vec64_writes", 256'(n_wr),       256'(2));
      chk("vec64_vec",    256'(n_vec),      256'(2));
      chk("vec64_mat",    256'(n_mat),      256'(0));
      chk("vec64_bid0",   256'(cap_bid[0]), 256'(3));
      chk("vec64_bid1",   256'(cap_bid[1]), 256'(3));
      chk("vec64_tile0",  cap[0],           ramp(0, 32));
      chk("vec64_tile1",  cap[1],           ramp(32, 32));
      chk("vec64_done",   256'(n_done),     256'(1));
      chk("vec64_both",   256'(viol_both),  256'(0));

      // Matrix, partial final tile
      cmd(1'b1, 24'h000200, 20'd40, 5'd1);
      wait_idle("mat40");
      chk("mat40_writes", 256'(n_wr),       256'(2));
      chk("mat40_mat",    256'(n_mat),      256'(2));
      chk("mat40_vec",    256'(n_vec),      256'(0));
      chk("mat40_bid1",   256'(cap_bid[1]), 256'(1));
      chk("mat40_tile0",  cap[0],           ramp(0, 32));
      chk("mat40_tile1",  cap[1],           ramp(32, 8));
      chk("mat40_upper",  256'(cap[1][255:64]), 256'(0));
      chk("mat40_done",   256'(n_done),     256'(1));

      // Zero length
      cmd(1'b0, 24'h000500, 20'd0, 5'd9);
      chk("len0_done_next", 256'(done), 256'(1));
      wait_idle("len0");
      chk("len0_req",    256'(n_req_cyc), 256'(0));
      chk("len0_writes", 256'(n_wr),      256'(0));
      chk("len0_done",   256'(n_done),    256'(1));

      // Slow memory, address wrapping past 2^24
      gnt_dly = 3; rv_dly = 5;
      cmd(1'b0, 24'hFFFFF0, 20'd32, 5'd7);
      wait_idle("slow");
      chk("slow_addr_stable", 256'(viol_addr),  256'(0));
      chk("slow_one_outst",   256'(viol_multi), 256'(0));
      chk("slow_req_cycles",  256'(n_req_cyc),  256'(128));
      chk("slow_writes",      256'(n_wr),       256'(1));
      chk("slow_bid",         256'(cap_bid[0]), 256'(7));
      chk("slow_tile_wrap",   cap[0],           ramp(240, 32));
      gnt_dly = 0; rv_dly = 0;

      // Start while busy is ignored
      cmd(1'b0, 24'h000040, 20'd32, 5'd5);
      repeat (4) @(negedge clk);
      is_matrix = 1'b1; buffer_id = 5'd9; length = 20'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle("busy_start");
      chk("busy_start_writes", 256'(n_wr),       256'(1));
      chk("busy_start_mat",    256'(n_mat),      256'(0));
      chk("busy_start_bid",    256'(cap_bid[0]), 256'(5));
      chk("busy_start_tile",   cap[0],           ramp(64, 32));
      chk("busy_start_done",   256'(n_done),     256'(1));

      // Reset mid-command, then a clean command
      cmd(1'b0, 24'h000300, 20'd32, 5'd2);
      for (int i = 0; i < 500 && n_rv < 10; i++) @(negedge clk);
      chk("midrst_reached", 256'(n_rv >= 10), 256'(1));
      @(negedge clk);
      rst = 1'b1;
      #1;
      zchk("midrst");
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("midrst_writes", 256'(n_wr),   256'(0));
      chk("midrst_done",   256'(n_done), 256'(0));
      chk("midrst_idle",   256'(busy),   256'(0));
      cmd(1'b0, 24'h000300, 20'd32, 5'd2);
      wait_idle("after_rst");
      chk("after_rst_writes", 256'(n_wr),       256'(1));
      chk("after_rst_bid",    256'(cap_bid[0]), 256'(2));
      chk("after_rst_tile",   cap[0],           ramp(0, 32));
      chk("after_rst_done",   256'(n_done),     256'(1));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/tile_load_engine.md
TILE_LOAD_ENGINE -- requirements
Module: tile_load_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, element width in bits.
REQ-002 SHALL have parameter TILE_ELEMS, default 32, elements per tile.
REQ-003 SHALL have parameter TILE_WIDTH, default 256, equal to DATA_WIDTH*TILE_ELEMS.
REQ-004 SHALL have parameter ADDR_WIDTH, default 24, memory byte-address width.
REQ-005 SHALL have parameter LEN_WIDTH, default 20, element-count width.
REQ-006 SHALL have ports: clk in 1, rising-edge clock; rst in 1, reset.
REQ-007 SHALL state the decided reset/clock scheme exactly: reset rst, asynchronous, active-high; clock clk.
REQ-008 SHALL have command ports: start in 1, command strobe; is_matrix in 1, 1 = matrix target, 0 = vector target; base_addr in ADDR_WIDTH, first element byte address; length in LEN_WIDTH, element count; buffer_id in 5, destination buffer.
REQ-009 SHALL have status ports: busy out 1, command in progress; done out 1, one-cycle completion pulse.
REQ-010 SHALL have memory ports: mem_req out 1, read request valid; mem_addr out ADDR_WIDTH, request address; mem_gnt in 1, request accepted; mem_rvalid in 1, read data valid; mem_rdata in DATA_WIDTH, read byte.
REQ-011 SHALL have vector-write ports: vec_write_enable out 1; vec_write_buffer_id out 5; vec_write_tile out signed DATA_WIDTH x [0:TILE_ELEMS-1].
REQ-012 SHALL have matrix-write ports: mat_write_enable out 1; mat_write_buffer_id out 5; mat_write_tile out TILE_WIDTH, packed.

Function
REQ-013 SHALL implement FSM states IDLE, REQ, WAIT, WRITE, DONE.
REQ-014 SHALL accept start only in IDLE; on acceptance, latch is_matrix, base_addr, length and buffer_id, clear the tile register and element counters, and enter REQ if length>0, else DONE.
REQ-015 SHALL ignore start in every state other than IDLE.
REQ-016 SHALL hold mem_req=1 and a stable mem_addr throughout REQ; mem_addr SHALL equal base_addr + elements already received.
REQ-017 SHALL move REQ->WAIT on the cycle mem_req && mem_gnt; at most one request SHALL be outstanding.
REQ-018 SHALL, in WAIT on mem_rvalid, store mem_rdata in tile slot k = (element index mod TILE_ELEMS) and increment the element count.
REQ-019 SHALL go WAIT->WRITE when slot TILE_ELEMS-1 or the last element is filled; otherwise WAIT->REQ.
REQ-020 SHALL ignore mem_rvalid outside WAIT.
REQ-021 SHALL, in WRITE, assert exactly one of vec_write_enable/mat_write_enable (per latched is_matrix) for exactly one cycle; the selected buffer_id output SHALL equal the latched buffer_id and the tile output SHALL be valid in that cycle.
REQ-022 SHALL place slot k at vec_write_tile[k], or at mat_write_tile[k*DATA_WIDTH +: DATA_WIDTH].
REQ-023 SHALL zero-fill slots beyond the last element in a partial final tile.
REQ-024 SHALL, after WRITE, clear the tile register, then enter REQ if elements remain, else DONE.
REQ-025 SHALL pulse done for exactly the one cycle spent in DONE, then return to IDLE.
REQ-026 SHALL drive busy=1 in every state except IDLE.
REQ-027 SHALL issue ceil(length/TILE_ELEMS) write pulses per command, in tile order.
REQ-028 SHALL compute addresses modulo 2^ADDR_WIDTH, wrapping without error.

Reset
REQ-029 SHALL, on rst, enter IDLE immediately, including mid-command, discarding any partial tile without issuing a write.
REQ-030 SHALL drive busy, done, mem_req, both write enables, mem_addr, both buffer_id outputs and both tile outputs to 0 during reset.
REQ-031 SHALL not respond to an outstanding memory response after reset releases.

Verification
REQ-032 SHALL verify: vector, base 0x000100, length 64, buffer 3, zero-latency memory returning byte = addr[7:0] -> two vec writes to buffer 3; tile0[k]=k, tile1[k]=32+k; done once; no mat write.
REQ-033 SHALL verify: matrix, length 40, buffer 1 -> two mat writes; second tile bytes 0..7 = data, bits [255:64] = 0.
REQ-034 SHALL verify: length 0 -> done one cycle after start acceptance, no mem_req, no write.
REQ-035 SHALL verify: mem_gnt delayed 3 cycles and mem_rvalid delayed 5 cycles -> mem_addr stable while mem_req is high, and only one request is outstanding.
REQ-036 SHALL verify: start pulsed while busy with different buffer_id -> ignored; writes use the original id.
REQ-037 SHALL verify: rst asserted after 10 of 32 bytes -> all outputs 0, no write pulse; a new command then completes normally.
